// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: command encoding and I/O register addresses.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } mem_cmd_t;

    // Bit 8 of the bus address selects I/O space.
    localparam logic [8:0] ADDR_LED        = 9'h100;
    localparam logic [8:0] ADDR_SW         = 9'h140;
    localparam logic [8:0] ADDR_CYCLE      = 9'h180;
    localparam logic [8:0] ADDR_DBG_TX     = 9'h1C0;
    localparam logic [8:0] ADDR_DBG_STATUS = 9'h1C1;

endpackage

// File: rtl/dbg_tx_fifo.sv
// Debug byte-transmit FIFO. Pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter register.
module dbg_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so reset and drained states look identical.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side bus responder: 256x16 RAM plus memory-mapped LEDs, switches,
// cycle counter and debug TX FIFO. Reads answer with a one-cycle rvalid strobe.
module mem_io_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW     = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LED_W      = 10,
    parameter int unsigned SW_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [DW-1:0]     mem_wdata,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_rvalid,
    input  logic [SW_W-1:0]   sw_async,
    output logic [LED_W-1:0]  led,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    mem_cmd_t cmd;
    logic     is_rd, is_wr, is_ram;

    logic [DW-1:0]    ram [2**RAM_AW];
    logic [DW-1:0]    ram_rd_q;
    logic [DW-1:0]    io_rd_q;
    logic [DW-1:0]    io_val;
    logic             sel_ram_q;
    logic             rvalid_q;
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [15:0]      cycle_q;
    logic             ovf_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_evt;
    logic [CW-1:0]    fifo_count;

    assign cmd    = mem_cmd_t'(mem_cmd);
    assign is_rd  = (cmd == CMD_READ);
    assign is_wr  = (cmd == CMD_WRITE);
    assign is_ram = !mem_addr[8];

    assign fifo_push = is_wr && (mem_addr == ADDR_DBG_TX);
    assign fifo_pop  = tx_valid && tx_ready;
    assign ovf_evt   = fifo_push && fifo_full && !fifo_pop;
    assign tx_valid  = !fifo_empty;

    // I/O read mux, sampled into io_rd_q on an I/O READ.
    always_comb begin
        io_val = '0;
        case (mem_addr)
            ADDR_LED:        io_val[LED_W-1:0] = led_q;
            ADDR_SW:         io_val[SW_W-1:0]  = sw_sync_q;
            ADDR_CYCLE:      io_val[15:0]      = cycle_q;
            ADDR_DBG_STATUS: io_val[2:0]       = {ovf_q, fifo_count == CW'(FIFO_DEPTH),
                                                  fifo_count == '0};
            default:         io_val            = '0;
        endcase
    end

    // Read response path; the source registers only update on a READ, so rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q  <= 1'b0;
            sel_ram_q <= 1'b0;
            io_rd_q   <= '0;
        end else begin
            rvalid_q <= is_rd;
            if (is_rd)            sel_ram_q <= is_ram;
            if (is_rd && !is_ram) io_rd_q   <= io_val;
        end
    end

    // Block RAM with synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && is_wr && is_ram) ram[mem_addr[RAM_AW-1:0]] <= mem_wdata;
        if (rst_n && is_rd && is_ram) ram_rd_q <= ram[mem_addr[RAM_AW-1:0]];
    end

    assign mem_rdata  = sel_ram_q ? ram_rd_q : io_rd_q;
    assign mem_rvalid = rvalid_q;

    // LED register, switch synchronizer, cycle counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cycle_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_async;
            sw_sync_q <= sw_meta_q;
            if (is_wr && mem_addr == ADDR_LED) led_q <= mem_wdata[LED_W-1:0];
            cycle_q <= (is_wr && mem_addr == ADDR_CYCLE) ? 16'd0 : cycle_q + 16'd1;
            // A new overflow beats a simultaneous status clear.
            if (ovf_evt)                                    ovf_q <= 1'b1;
            else if (is_wr && mem_addr == ADDR_DBG_STATUS)  ovf_q <= 1'b0;
        end
    end

    assign led = led_q;

    dbg_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_dbg_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (mem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
